// File: rtl/countdown_pkg.sv
// Shared types and sizing for the countdown sequencer that drives the 4-bit down counter.
package countdown_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DIV_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/countdown_ctrl_if.sv
// Request and counter-facing signals of countdown_ctrl, grouped into one bundle.
interface countdown_ctrl_if #(
  parameter int WIDTH = countdown_pkg::WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] start_val;
  logic             abort;
  logic [WIDTH-1:0] cnt_in;
  logic             zero_in;
  logic             latch_out;
  logic [WIDTH-1:0] in_out;
  logic             dec_out;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, start_val, abort, cnt_in, zero_in,
    input  latch_out, in_out, dec_out, busy, done, err
  );

  modport slave (
    input  start, start_val, abort, cnt_in, zero_in,
    output latch_out, in_out, dec_out, busy, done, err
  );
endinterface

// File: rtl/countdown_ctrl_tick_div.sv
// Dec-rate prescaler: while enabled, tick is high once every DIV cycles, on the last one.
module tick_div
  import countdown_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Sequences latch/dec pulses into the down counter and shadows its count to detect tracking errors.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  countdown_ctrl_if.slave  ctl
);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_in;
  logic             r_latch;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             w_tick;
  logic             w_dec;
  logic             w_accept;
  logic             w_set_err;
  logic             w_run;
  logic             w_mismatch;

  assign w_run      = (r_state == RUN);
  assign w_mismatch = w_run && (ctl.cnt_in != r_shadow);

  tick_div #(.DIV(DIV)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (!w_run),
    .en   (w_run),
    .tick (w_tick)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_dec     = 1'b0;
    w_accept  = 1'b0;
    w_set_err = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ctl.start && !ctl.abort) begin
          w_next   = LOAD;
          w_accept = 1'b1;
        end
      end
      LOAD: w_next = ctl.abort ? IDLE : RUN;
      RUN: begin
        // Abort beats the tracking check, which beats completion, which beats a dec.
        if (ctl.abort) begin
          w_next = IDLE;
        end else if (w_mismatch) begin
          w_next    = IDLE;
          w_set_err = 1'b1;
        end else if (ctl.zero_in) begin
          w_next = DONE;
        end else if (w_tick) begin
          w_dec = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_in     <= '0;
      r_latch  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_latch <= (w_next == LOAD);
      r_busy  <= (w_next != IDLE);
      r_done  <= (w_next == DONE);
      if (w_accept) begin
        r_in     <= ctl.start_val;
        r_shadow <= ctl.start_val;
        r_err    <= 1'b0;
      end else begin
        if (w_set_err) r_err <= 1'b1;
        // Shadow steps on the same edge the counter consumes the dec.
        if (w_dec) r_shadow <= r_shadow - WIDTH'(1);
      end
    end
  end

  assign ctl.latch_out = r_latch;
  assign ctl.in_out    = r_in;
  assign ctl.dec_out   = w_dec;
  assign ctl.busy      = r_busy;
  assign ctl.done      = r_done;
  assign ctl.err       = r_err;

endmodule
